// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide width plus data-memory request and arbiter state types
package riscv_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [3:0]      we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;
  typedef enum logic {ARB_IDLE, ARB_B_PEND} arb_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counts cycles with inc high, saturating at all-ones (clk_i, rstn_i, inc in; cnt out)
module sat_counter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             inc,
  output logic [Width-1:0] cnt
);
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + Width'(1);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises lane A then lane B onto one dmem port (lane req/ready in/out, lane rsp out, dmem port, stall_o, conflict_cnt_o)
module dmem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                flush_i,
  input  logic                req_a_valid_i,
  input  logic [3:0]          req_a_we_i,
  input  logic [XLEN-1:0]     req_a_addr_i,
  input  logic [XLEN-1:0]     req_a_wdata_i,
  output logic                req_a_ready_o,
  input  logic                req_b_valid_i,
  input  logic [3:0]          req_b_we_i,
  input  logic [XLEN-1:0]     req_b_addr_i,
  input  logic [XLEN-1:0]     req_b_wdata_i,
  output logic                req_b_ready_o,
  output logic                rsp_a_valid_o,
  output logic [XLEN-1:0]     rsp_a_rdata_o,
  output logic                rsp_b_valid_o,
  output logic [XLEN-1:0]     rsp_b_rdata_o,
  output logic                stall_o,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  output logic [3:0]          dmem_we_o,
  output logic                dmem_re_o,
  input  logic [XLEN-1:0]     dmem_rdata_i,
  output logic [CntWidth-1:0] conflict_cnt_o
);
  arb_state_e      state_q, state_d;
  dmem_req_t       req_a, req_b, req_sel;
  logic            sel_a, sel_b, rd_q, lane_q;
  logic [XLEN-1:0] hold_a_q, hold_b_q;
  assign req_a = '{we: req_a_we_i, addr: req_a_addr_i, wdata: req_a_wdata_i};
  assign req_b = '{we: req_b_we_i, addr: req_b_addr_i, wdata: req_b_wdata_i};
  always_comb begin
    sel_a   = !flush_i && state_q == ARB_IDLE && req_a_valid_i;
    sel_b   = !flush_i && req_b_valid_i && (state_q == ARB_B_PEND || !req_a_valid_i);
    stall_o = sel_a && req_b_valid_i;
    state_d = stall_o ? ARB_B_PEND : ARB_IDLE;
    req_sel = sel_a ? req_a : sel_b ? req_b : '0;
  end
  assign req_a_ready_o = sel_a;
  assign req_b_ready_o = sel_b;
  assign dmem_addr_o   = req_sel.addr;
  assign dmem_wdata_o  = req_sel.wdata;
  assign dmem_we_o     = req_sel.we;
  assign dmem_re_o     = (sel_a || sel_b) && req_sel.we == 4'h0;
  assign rsp_a_valid_o = rd_q && !lane_q;
  assign rsp_b_valid_o = rd_q && lane_q;
  assign rsp_a_rdata_o = rsp_a_valid_o ? dmem_rdata_i : hold_a_q;
  assign rsp_b_rdata_o = rsp_b_valid_o ? dmem_rdata_i : hold_b_q;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q  <= ARB_IDLE;
      rd_q     <= 1'b0;
      lane_q   <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= dmem_re_o;
      lane_q  <= sel_b;
      if (rsp_a_valid_o) hold_a_q <= dmem_rdata_i;
      if (rsp_b_valid_o) hold_b_q <= dmem_rdata_i;
    end
  sat_counter #(.Width(CntWidth)) u_conflict_cnt (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .inc   (stall_o),
    .cnt   (conflict_cnt_o)
  );
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed plus randomized checks of the two-lane dmem arbiter against a memory model
module tb_dmem_port_arbiter;
  logic        clk = 0, rstn_i = 0, flush_i = 0;
  logic        req_a_valid_i = 0, req_b_valid_i = 0;
  logic [3:0]  req_a_we_i = 0, req_b_we_i = 0;
  logic [31:0] req_a_addr_i = 0, req_a_wdata_i = 0, req_b_addr_i = 0, req_b_wdata_i = 0;
  logic        req_a_ready_o, req_b_ready_o, rsp_a_valid_o, rsp_b_valid_o, stall_o, dmem_re_o;
  logic [31:0] rsp_a_rdata_o, rsp_b_rdata_o, dmem_addr_o, dmem_wdata_o;
  logic [31:0] dmem_rdata_i = 0;
  logic [3:0]  dmem_we_o;
  logic [1:0]  conflict_cnt_o;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  int tests = 0, fails = 0;
  typedef struct {logic lane; logic [31:0] data;} rsp_t;
  rsp_t exp_q[$];
  always #5 clk = ~clk;
  dmem_port_arbiter #(.CntWidth(2)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .flush_i(flush_i),
    .req_a_valid_i(req_a_valid_i), .req_a_we_i(req_a_we_i), .req_a_addr_i(req_a_addr_i),
    .req_a_wdata_i(req_a_wdata_i), .req_a_ready_o(req_a_ready_o),
    .req_b_valid_i(req_b_valid_i), .req_b_we_i(req_b_we_i), .req_b_addr_i(req_b_addr_i),
    .req_b_wdata_i(req_b_wdata_i), .req_b_ready_o(req_b_ready_o),
    .rsp_a_valid_o(rsp_a_valid_o), .rsp_a_rdata_o(rsp_a_rdata_o),
    .rsp_b_valid_o(rsp_b_valid_o), .rsp_b_rdata_o(rsp_b_rdata_o),
    .stall_o(stall_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_we_o(dmem_we_o), .dmem_re_o(dmem_re_o), .dmem_rdata_i(dmem_rdata_i),
    .conflict_cnt_o(conflict_cnt_o)
  );
  always @(posedge clk) begin
    if (dmem_re_o) dmem_rdata_i <= mem[dmem_addr_o[11:2]];
    for (int i = 0; i < 4; i++)
      if (dmem_we_o[i]) mem[dmem_addr_o[11:2]][8*i +: 8] = dmem_wdata_o[8*i +: 8];
  end
  task automatic set_a(input logic v, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    req_a_valid_i = v; req_a_we_i = we; req_a_addr_i = addr; req_a_wdata_i = wd;
  endtask
  task automatic set_b(input logic v, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    req_b_valid_i = v; req_b_we_i = we; req_b_addr_i = addr; req_b_wdata_i = wd;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); flush_i = 0;
    rstn_i = 0; repeat (2) @(posedge clk);
    @(negedge clk); rstn_i = 1; step();
  endtask
  function automatic void model_access(input logic lane, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    rsp_t r;
    if (we == 4'h0) begin
      r.lane = lane; r.data = ref_mem[addr[11:2]]; exp_q.push_back(r);
    end else
      for (int i = 0; i < 4; i++) if (we[i]) ref_mem[addr[11:2]][8*i +: 8] = wd[8*i +: 8];
  endfunction
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if ({rsp_a_valid_o, rsp_b_valid_o, stall_o, dmem_re_o, dmem_we_o} !== 8'h0 || conflict_cnt_o !== 2'd0) begin
      fails++; $display("FAIL reset_ctrl got va=%b vb=%b st=%b re=%b we=%h cnt=%0d want all 0", rsp_a_valid_o, rsp_b_valid_o, stall_o, dmem_re_o, dmem_we_o, conflict_cnt_o);
    end
    tests++;
    if ({rsp_a_rdata_o, rsp_b_rdata_o, dmem_addr_o, dmem_wdata_o} !== 128'h0) begin
      fails++; $display("FAIL reset_data got ra=%h rb=%h addr=%h wd=%h want 0", rsp_a_rdata_o, rsp_b_rdata_o, dmem_addr_o, dmem_wdata_o);
    end
  endtask
  task automatic test_a_read();
    set_a(1, 4'h0, 32'h100, 0);
    @(negedge clk);
    tests++;
    if ({dmem_re_o, req_a_ready_o, stall_o} !== 3'b110 || dmem_addr_o !== 32'h100) begin
      fails++; $display("FAIL a_read_issue got re=%b rdy=%b st=%b addr=%h want 1 1 0 100", dmem_re_o, req_a_ready_o, stall_o, dmem_addr_o);
    end
    step(); req_a_valid_i = 0;
    @(negedge clk);
    tests++;
    if ({rsp_a_valid_o, rsp_b_valid_o} !== 2'b10 || rsp_a_rdata_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL a_read_rsp got va=%b vb=%b data=%h want 1 0 deadbeef", rsp_a_valid_o, rsp_b_valid_o, rsp_a_rdata_o);
    end
    step();
  endtask
  task automatic test_store_load_pair();
    do_reset();
    set_a(1, 4'hF, 32'h200, 32'h11223344); set_b(1, 4'h0, 32'h200, 0);
    @(negedge clk);
    tests++;
    if ({stall_o, req_a_ready_o, req_b_ready_o, dmem_re_o, dmem_we_o} !== 8'b1100_1111 || dmem_wdata_o !== 32'h11223344) begin
      fails++; $display("FAIL pair_store got st=%b ra=%b rb=%b re=%b we=%h wd=%h want 1 1 0 0 f 11223344", stall_o, req_a_ready_o, req_b_ready_o, dmem_re_o, dmem_we_o, dmem_wdata_o);
    end
    step(); req_a_valid_i = 0;
    @(negedge clk);
    tests++;
    if ({stall_o, req_a_ready_o, req_b_ready_o, dmem_re_o} !== 4'b0011 || dmem_addr_o !== 32'h200) begin
      fails++; $display("FAIL pair_load got st=%b ra=%b rb=%b re=%b addr=%h want 0 0 1 1 200", stall_o, req_a_ready_o, req_b_ready_o, dmem_re_o, dmem_addr_o);
    end
    step(); req_b_valid_i = 0;
    @(negedge clk);
    tests++;
    if ({rsp_a_valid_o, rsp_b_valid_o} !== 2'b01 || rsp_b_rdata_o !== 32'h11223344 || conflict_cnt_o !== 2'd1) begin
      fails++; $display("FAIL pair_rsp got va=%b vb=%b data=%h cnt=%0d want 0 1 11223344 1", rsp_a_valid_o, rsp_b_valid_o, rsp_b_rdata_o, conflict_cnt_o);
    end
    step();
  endtask
  task automatic test_b_read();
    set_b(1, 4'h0, 32'h300, 0);
    @(negedge clk);
    tests++;
    if ({req_b_ready_o, stall_o, dmem_re_o} !== 3'b101 || dmem_addr_o !== 32'h300) begin
      fails++; $display("FAIL b_read_issue got rb=%b st=%b re=%b addr=%h want 1 0 1 300", req_b_ready_o, stall_o, dmem_re_o, dmem_addr_o);
    end
    step(); req_b_valid_i = 0;
    @(negedge clk);
    tests++;
    if ({rsp_a_valid_o, rsp_b_valid_o} !== 2'b01 || rsp_b_rdata_o !== 32'h5) begin
      fails++; $display("FAIL b_read_rsp got va=%b vb=%b data=%h want 0 1 5", rsp_a_valid_o, rsp_b_valid_o, rsp_b_rdata_o);
    end
    step();
  endtask
  task automatic test_flush();
    set_a(1, 4'h0, 32'h100, 0); set_b(1, 4'h0, 32'h300, 0);
    @(negedge clk);
    tests++;
    if ({stall_o, req_a_ready_o} !== 2'b11) begin
      fails++; $display("FAIL flush_setup got st=%b ra=%b want 1 1", stall_o, req_a_ready_o);
    end
    step(); req_a_valid_i = 0; flush_i = 1;
    @(negedge clk);
    tests++;
    if ({req_a_ready_o, req_b_ready_o, stall_o, dmem_re_o, dmem_we_o} !== 8'h0 || {rsp_a_valid_o, rsp_b_valid_o} !== 2'b10 || rsp_a_rdata_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL flush_cycle got ra=%b rb=%b st=%b re=%b we=%h va=%b vb=%b data=%h want 0 0 0 0 0 1 0 deadbeef", req_a_ready_o, req_b_ready_o, stall_o, dmem_re_o, dmem_we_o, rsp_a_valid_o, rsp_b_valid_o, rsp_a_rdata_o);
    end
    step(); flush_i = 0; req_b_valid_i = 0; set_a(1, 4'h0, 32'h300, 0);
    @(negedge clk);
    tests++;
    if ({rsp_a_valid_o, rsp_b_valid_o, req_a_ready_o, dmem_re_o} !== 4'b0011 || rsp_a_rdata_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL flush_after got va=%b vb=%b ra=%b re=%b hold=%h want 0 0 1 1 deadbeef", rsp_a_valid_o, rsp_b_valid_o, req_a_ready_o, dmem_re_o, rsp_a_rdata_o);
    end
    step(); req_a_valid_i = 0;
    @(negedge clk);
    tests++;
    if ({rsp_a_valid_o, rsp_b_valid_o} !== 2'b10 || rsp_a_rdata_o !== 32'h5) begin
      fails++; $display("FAIL flush_rsp got va=%b vb=%b data=%h want 1 0 5", rsp_a_valid_o, rsp_b_valid_o, rsp_a_rdata_o);
    end
    step();
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_a(1, 4'h0, 32'(4 * i), 0); else req_a_valid_i = 0;
      @(negedge clk);
      if (i > 0) begin
        tests++;
        if ({rsp_a_valid_o, rsp_b_valid_o} !== 2'b10 || rsp_a_rdata_o !== 32'(32'h1000_0000 + i - 1)) begin
          fails++; $display("FAIL b2b_rsp%0d got va=%b vb=%b data=%h want 1 0 %h", i - 1, rsp_a_valid_o, rsp_b_valid_o, rsp_a_rdata_o, 32'(32'h1000_0000 + i - 1));
        end
      end
      if (i < 4) begin
        tests++;
        if ({req_a_ready_o, stall_o, dmem_re_o} !== 3'b101) begin
          fails++; $display("FAIL b2b_issue%0d got ra=%b st=%b re=%b want 1 0 1", i, req_a_ready_o, stall_o, dmem_re_o);
        end
      end
      step();
    end
    tests++;
    if (conflict_cnt_o !== 2'd0) begin
      fails++; $display("FAIL b2b_cnt got %0d want 0", conflict_cnt_o);
    end
  endtask
  task automatic test_saturation_and_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_a(1, 4'h0, 32'h0, 0); set_b(1, 4'h0, 32'h4, 0);
      step(); req_a_valid_i = 0;
      @(negedge clk);
      tests++;
      if (conflict_cnt_o !== 2'(k >= 2 ? 3 : k + 1)) begin
        fails++; $display("FAIL sat_cnt%0d got %0d want %0d", k, conflict_cnt_o, k >= 2 ? 3 : k + 1);
      end
      step(); req_b_valid_i = 0;
    end
    set_a(1, 4'h0, 32'h0, 0); set_b(1, 4'h0, 32'h4, 0);
    step(); req_a_valid_i = 0;
    #2; rstn_i = 0; set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    #1;
    tests++;
    if ({rsp_a_valid_o, rsp_b_valid_o, stall_o, dmem_re_o, req_b_ready_o} !== 5'b0 || conflict_cnt_o !== 2'd0 || rsp_a_rdata_o !== 32'h0 || rsp_b_rdata_o !== 32'h0) begin
      fails++; $display("FAIL async_reset got va=%b vb=%b st=%b re=%b rb=%b cnt=%0d ra=%h rbd=%h want all 0", rsp_a_valid_o, rsp_b_valid_o, stall_o, dmem_re_o, req_b_ready_o, conflict_cnt_o, rsp_a_rdata_o, rsp_b_rdata_o);
    end
    @(posedge clk); @(negedge clk); rstn_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({rsp_a_valid_o, rsp_b_valid_o, dmem_re_o} !== 3'b0) begin
        fails++; $display("FAIL post_reset%0d got va=%b vb=%b re=%b want 0 0 0", i, rsp_a_valid_o, rsp_b_valid_o, dmem_re_o);
      end
    end
  endtask
  task automatic test_random();
    int n = 0, cyc = 0, guard = 0, stalls = 0;
    logic av = 0, bv = 0, ra, rb;
    logic [2:0] exp_hs;
    rsp_t r;
    do_reset();
    ref_mem = mem;
    exp_q.delete();
    while ((n < 80 || req_a_valid_i || req_b_valid_i || exp_q.size() != 0) && guard < 2000) begin
      if (!req_a_valid_i && !req_b_valid_i) begin
        av = 0; bv = 0; cyc = 0;
        if (n < 80) begin
          n++;
          av = $urandom_range(0, 3) != 0;
          bv = $urandom_range(0, 2) != 0;
          set_a(0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), 32'($urandom_range(0, 15)) << 2, $urandom);
          set_b(0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), 32'($urandom_range(0, 15)) << 2, $urandom);
          if (av) model_access(0, req_a_we_i, req_a_addr_i, req_a_wdata_i);
          if (bv) model_access(1, req_b_we_i, req_b_addr_i, req_b_wdata_i);
          stalls += int'(av && bv);
          req_a_valid_i = av; req_b_valid_i = bv;
        end
      end
      @(negedge clk);
      if (rsp_a_valid_o || rsp_b_valid_o) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rand_rsp unexpected va=%b vb=%b want none", rsp_a_valid_o, rsp_b_valid_o);
        end else begin
          r = exp_q.pop_front();
          if ({rsp_a_valid_o, rsp_b_valid_o} !== (r.lane ? 2'b01 : 2'b10) || (r.lane ? rsp_b_rdata_o : rsp_a_rdata_o) !== r.data) begin
            fails++; $display("FAIL rand_rsp got va=%b vb=%b ra=%h rb=%h want lane=%b data=%h", rsp_a_valid_o, rsp_b_valid_o, rsp_a_rdata_o, rsp_b_rdata_o, r.lane, r.data);
          end
        end
      end
      exp_hs = {av && cyc == 0, bv && cyc == (av ? 1 : 0), av && bv && cyc == 0};
      tests++;
      if ({req_a_ready_o, req_b_ready_o, stall_o} !== exp_hs) begin
        fails++; $display("FAIL rand_handshake pair=%0d cyc=%0d got ra/rb/st=%b want %b", n, cyc, {req_a_ready_o, req_b_ready_o, stall_o}, exp_hs);
      end
      ra = req_a_ready_o; rb = req_b_ready_o;
      step();
      if (ra) req_a_valid_i = 0;
      if (rb) req_b_valid_i = 0;
      cyc++; guard++;
      if (cyc > 3 && (req_a_valid_i || req_b_valid_i)) begin
        tests++; fails++;
        $display("FAIL rand_timeout pair=%0d still pending a=%b b=%b want accepted", n, req_a_valid_i, req_b_valid_i);
        req_a_valid_i = 0; req_b_valid_i = 0;
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL rand_drain got %0d responses missing want 0", exp_q.size());
    end
    tests++;
    if (conflict_cnt_o !== 2'(stalls > 3 ? 3 : stalls)) begin
      fails++; $display("FAIL rand_cnt got %0d want %0d", conflict_cnt_o, stalls > 3 ? 3 : stalls);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h300 >> 2] = 32'h5;
    for (int i = 0; i < 4; i++) mem[i] = 32'(32'h1000_0000 + i);
    test_reset();
    test_a_read();
    test_store_load_pair();
    test_b_read();
    test_flush();
    test_back_to_back();
    test_saturation_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
